// File: rtl/vsalu_sched_pkg.sv
// ============================================================================
// Module      : vsalu_pkg
// Description : Shared constants for the VSALU scheduler: opcode map,
//               divide-by-zero result and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vsalu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MOD  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;

  // Highest implemented opcode; anything above is flagged as an error
  localparam logic [3:0] OP_LAST = 4'hB;

  // Result reported for a divide by zero
  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vsalu_sched_if.sv
// ============================================================================
// Module      : vsalu_sched_if
// Description : Two-requester operation/response bus of the VSALU scheduler.
//               Lane i of each packed vector belongs to requester i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vsalu_sched_if #(
  parameter int DW  = 8,
  parameter int OPW = 4
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*DW-1:0]  req_opa;
  logic [2*DW-1:0]  req_opb;
  logic [2*OPW-1:0] req_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;

  // Requester side
  modport master (
    output req_valid, req_opa, req_opb, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_opa, req_opb, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/vsalu_rr_arb2.sv
// ============================================================================
// Module      : vsalu_rr_arb2
// Description : Two-way round-robin arbiter. On contention the requester
//               that did not win last time is granted. Grant is one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vsalu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant, suppressed entirely when not enabled
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vsalu_sched.sv
// ============================================================================
// Module      : vsalu_sched
// Description : Shares one combinational VSALU between two requesters.
//               IDLE grants and latches operands, EXEC samples the ALU,
//               RESP holds the result until the granted requester takes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vsalu_sched
  import vsalu_pkg::*;
#(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  vsalu_sched_if.slave    bus,
  output logic [DW-1:0]   alu_opa,
  output logic [DW-1:0]   alu_opb,
  output logic [OPW-1:0]  alu_mux,
  input  logic [DW-1:0]   alu_result,
  output logic            busy
);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_gidx;
  logic [DW-1:0]    r_opa;
  logic [DW-1:0]    r_opb;
  logic [OPW-1:0]   r_mux;
  logic [1:0]       r_rsp_valid;
  logic [DW-1:0]    r_rsp_data;
  logic             r_rsp_err;

  logic             w_arb_en;
  logic [1:0]       w_grant;
  logic             w_gsel;
  logic [DW-1:0]    w_sel_opa;
  logic [DW-1:0]    w_sel_opb;
  logic [OPW-1:0]   w_sel_op;
  logic             w_div0;
  logic             w_illegal;

  // Requests are only considered in IDLE and never while reset is held
  assign w_arb_en = rst_n && (r_state == IDLE);

  vsalu_rr_arb2 u_arb (
    .req        (bus.req_valid),
    .en         (w_arb_en),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign w_gsel    = w_grant[1];
  assign w_sel_opa = w_gsel ? bus.req_opa[2*DW-1:DW]  : bus.req_opa[DW-1:0];
  assign w_sel_opb = w_gsel ? bus.req_opb[2*DW-1:DW]  : bus.req_opb[DW-1:0];
  assign w_sel_op  = w_gsel ? bus.req_op[2*OPW-1:OPW] : bus.req_op[OPW-1:0];

  assign w_illegal = (r_mux > OPW'(OP_LAST));
  assign w_div0    = (r_mux == OPW'(OP_DIV)) && (r_opb == '0);

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign alu_opa       = r_opa;
  assign alu_opb       = r_opb;
  assign alu_mux       = r_mux;
  assign busy          = (r_state != IDLE);

  // Scheduler FSM: grant/latch, sample ALU, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_gidx       <= 1'b0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_mux        <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != 2'b00) begin
            r_gidx       <= w_gsel;
            r_last_grant <= w_gsel;
            r_opa        <= w_sel_opa;
            r_opb        <= w_sel_opb;
            r_mux        <= w_sel_op;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          if (w_illegal) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else if (w_div0) begin
            r_rsp_data <= DW'(DIV0_RESULT);
            r_rsp_err  <= 1'b1;
          end else begin
            r_rsp_data <= alu_result;
            r_rsp_err  <= 1'b0;
          end
          r_rsp_valid <= r_gidx ? 2'b10 : 2'b01;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[r_gidx]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/vsalu_sched.md
Name: vsalu_sched

Overview:
- Shares one combinational 8-bit VSALU datapath between two requesters using a round-robin arbiter.
- Each requester issues an operation (opa, opb, 4-bit opcode) with a valid/ready handshake and receives a registered result with a valid/ready handshake.
- Sits between requester logic and the VSALU instance. It drives the ALU's opa/opb/mux inputs and samples its result.
- Also flags divide-by-zero and unimplemented opcodes.

Parameters:
- DW, 8, operand/result width; must match the ALU width.
- OPW, 4, opcode width (ALU mux select).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i = requester i has an operation pending.
- req_ready  out  2  one-hot pulse: operation of requester i accepted this cycle.
- req_opa  in  2*DW  operand A; bits [DW*i +: DW] belong to requester i.
- req_opb  in  2*DW  operand B, same packing.
- req_op  in  2*OPW  opcode, same packing (0x0..0xB legal).
- rsp_valid  out  2  bit i = result for requester i is held on rsp_data.
- rsp_ready  in  2  bit i = requester i consumes the result.
- rsp_data  out  DW  result of the current transaction.
- rsp_err  out  1  error flag qualifying rsp_data.
- alu_opa  out  DW  to ALU opa.
- alu_opb  out  DW  to ALU opb.
- alu_mux  out  OPW  to ALU mux.
- alu_result  in  DW  from ALU result (combinational).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0. State = IDLE.
  - Operand and opcode latches are 0.
  - last_grant = 1, so requester 0 wins first.
  - Reset asserted in any state aborts the transaction silently; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req_valid == 0, stay in IDLE.
  - Otherwise select the grant g:
    - Only one bit set: g = that requester.
    - Both bits set: g = ~last_grant.
  - In the same cycle:
    - req_ready[g] = 1 (combinational, one cycle).
    - Latch opa/opb/op of g.
    - last_grant <= g.
    - Next state EXEC.
- EXEC (exactly one cycle):
  - alu_opa/alu_opb/alu_mux are driven from the latches. These registered outputs update on the IDLE->EXEC edge and hold until the next grant.
  - At the end of the cycle capture the result into rsp_data:
    - op <= 0xB and not (op == 0x3 and opb == 0): rsp_data = alu_result, rsp_err = 0.
    - op == 0x3 and opb == 0: rsp_data = 8'hFF, rsp_err = 1.
    - op >= 0xC: rsp_data = 0, rsp_err = 1.
  - Next state RESP.
- RESP:
  - rsp_valid[g] = 1. rsp_data and rsp_err are held stable.
  - When rsp_ready[g] = 1 in the same cycle, the response completes: rsp_valid <= 0 and next state IDLE.
  - rsp_ready of the non-granted requester is ignored.
  - No new request is accepted during EXEC or RESP; req_ready = 0.
- Latency: request accepted in cycle t, rsp_valid asserted in cycle t+2. Minimum issue interval is 3 cycles per op with rsp_ready tied high.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1...
  - A requester that drops req_valid before acceptance loses nothing; its request is simply not granted.
- Arithmetic:
  - Results are truncated to DW bits, inherited from the ALU.
  - Mul keeps the low 8 bits; add/sub wrap modulo 256.
  - The controller never alters a legal result.
- rsp_data and rsp_err keep their last value after the handshake until the next capture.
- busy = 1 in EXEC and RESP, 0 in IDLE.

Decomposition:
- Shared package (vsalu_pkg) holds:
  - Opcode constants OP_ADD=0x0 … OP_SHR=0xB.
  - OP_LAST = 0xB.
  - DIV0_RESULT = 8'hFF.
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2).
- One natural sub-module: vsalu_rr_arb2. It is a 2-way round-robin arbiter with inputs req[1:0], an enable, and last_grant state, and outputs a one-hot grant.
- The ALU itself stays outside this block.

Test Plan:
- Single add: req 0 with opa=0x6A, opb=0x3B, op=0x0, rsp_ready=1.
  - Cycle t: req_ready=01.
  - Cycle t+2: rsp_valid=01, rsp_data=0xA5, rsp_err=0.
- Sub and AND via requester 1 with the same operands:
  - Sub gives rsp_data=0x2F.
  - AND gives rsp_data=0x2A.
  - rsp_valid=10 in both cases.
- Divide-by-zero: opa=0x6A, opb=0x00, op=0x3 -> rsp_data=0xFF, rsp_err=1. Illegal op=0xD -> rsp_data=0x00, rsp_err=1.
- Contention: both req_valid held high for 4 transactions -> grant order 0,1,0,1, each 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready stays 0. rsp_ready=1 -> returns to IDLE next cycle.
- Reset mid-EXEC: drop rsp_ready... assert rst_n=0 during EXEC -> all outputs 0 immediately. After release, a new request from requester 0 is granted first.
